// File: rtl/uart_pkg.sv
// uart_pkg: shared types and register bit positions for the UART ports.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int ST_BUSY     = 31;
    localparam int ST_FULL     = 30;
    localparam int ST_EMPTY    = 29;
    localparam int ST_OVF      = 28;
    localparam int CMD_CLR_OVF = 31;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Full is judged on the pre-edge count, so a push while full is dropped even with a pop
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: bus-slot UART transmitter; CPU bytes queue in a FIFO and leave as 8N1 frames.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        TX
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        state, state_nxt;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift, head;
    logic             ovf, tx_d, busy, pop, tick, wr_byte, full, empty;
    logic [CNT_W-1:0] count;
    logic             unused_wd;

    assign unused_wd = ^WD[30:8];
    assign wr_byte   = WE && !WD[CMD_CLR_OVF];
    assign tick      = baud_cnt == 16'(CLK_DIV - 1);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (wr_byte),
        .pop   (pop),
        .din   (WD[7:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : START;
            START:   state_nxt = tick ? DATA : START;
            DATA:    state_nxt = (tick && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    state_nxt = tick ? IDLE : STOP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        pop  = state == IDLE && !empty;
        tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end

    // TX is registered, so the line follows the state by one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TX       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            ovf      <= 1'b0;
        end else begin
            TX       <= tx_d;
            baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 16'd1;
            bit_idx  <= state == START ? 3'd0 : (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
            shift    <= pop ? head : (state == DATA && tick) ? {1'b0, shift[7:1]} : shift;
            ovf      <= (WE && WD[CMD_CLR_OVF]) ? 1'b0 : (wr_byte && full) ? 1'b1 : ovf;
        end
    end

    always_comb begin
        RD              = '0;
        RD[ST_BUSY]     = busy;
        RD[ST_FULL]     = full;
        RD[ST_EMPTY]    = empty;
        RD[ST_OVF]      = ovf;
        RD[CNT_W-1:0]   = count;
    end

endmodule
